// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO-to-stream adapter: buffer sizing,
// statistics counter width/struct and saturating counter update.
package fifo_stream_pkg;

    localparam int STAT_W = 32;

    typedef struct packed {
        logic [STAT_W-1:0] beats;
        logic [STAT_W-1:0] stalls;
    } stream_stats_t;

    // One slot per cycle of read latency plus two to keep full rate under backpressure.
    function automatic int buf_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    function automatic stream_stats_t stats_next(input stream_stats_t cur,
                                                 input logic beat,
                                                 input logic stall);
        stream_stats_t nxt;
        nxt = cur;
        if (beat) begin
            nxt.beats = sat_inc(cur.beats);
        end else begin
            nxt.beats = cur.beats;
        end
        if (stall) begin
            nxt.stalls = sat_inc(cur.stalls);
        end else begin
            nxt.stalls = cur.stalls;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_stream_adapter_chk.sv
// Property checker for the adapter: the skid buffer is never over-committed.
module fifo_stream_adapter_chk #(
    parameter int BUF_DEPTH = 2,
    parameter int OCC_W     = 2
) (
    input logic             clk,
    input logic             reset,
    input logic [OCC_W-1:0] occ,
    input logic             inflight
);

    logic [OCC_W:0] pending_s;

    assign pending_s = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

    a_no_overcommit: assert property (@(posedge clk) disable iff (reset)
        pending_s <= (OCC_W + 1)'(BUF_DEPTH));

endmodule

// File: rtl/stream_skid_buf.sv
// Small circular skid buffer: push/pop with occupancy; head word is read
// straight from the registered storage.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [OCC_W-1:0] occ_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Storage is deliberately not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign occ       = occ_r;
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a synchronous FIFO read port into a valid/ready stream at full rate.
// Optional statistics outputs are enabled by FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int READ_LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_ren,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_beats,
    output logic [STAT_W-1:0] stat_stalls,
    output logic              stat_starve
`endif
);

    localparam int BUF_DEPTH = buf_depth(READ_LATENCY);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    logic [OCC_W-1:0] occ_s;
    logic [OCC_W:0]   pending_s;
    logic             inflight_s;
    logic             push_s;
    logic             pop_s;
    logic             ren_s;

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("fifo_stream_adapter: READ_LATENCY must be 0 or 1");
    end

    // Issue depends only on registered state and fifo_empty, never on m_ready.
    assign pending_s = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_s};
    assign ren_s     = !reset && !fifo_empty && (pending_s < (OCC_W + 1)'(BUF_DEPTH));
    assign fifo_ren  = ren_s;

    if (READ_LATENCY == 1) begin : g_registered_read
        logic inflight_r;

        // Tracks the read issued last cycle whose data lands this cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                inflight_r <= 1'b0;
            end else begin
                inflight_r <= ren_s;
            end
        end

        assign inflight_s = inflight_r;
        assign push_s     = inflight_r;
    end else begin : g_fwft_read
        assign inflight_s = 1'b0;
        assign push_s     = ren_s;
    end

    assign m_valid = (occ_s != {OCC_W{1'b0}});
    assign pop_s   = m_valid && m_ready;

    stream_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (fifo_dout),
        .pop       (pop_s),
        .occ       (occ_s),
        .head_data (m_data)
    );

    fifo_stream_adapter_chk #(
        .BUF_DEPTH (BUF_DEPTH),
        .OCC_W     (OCC_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .occ      (occ_s),
        .inflight (inflight_s)
    );

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [STAT_W-1:0] beat_cnt_r;
    logic [STAT_W-1:0] stall_cnt_r;
    stream_stats_t     stats_s;
    stream_stats_t     stats_nxt_s;

    assign stats_s     = '{beats: beat_cnt_r, stalls: stall_cnt_r};
    assign stats_nxt_s = stats_next(stats_s, pop_s, m_valid && !m_ready);

    // Saturating transfer and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_r  <= {STAT_W{1'b0}};
            stall_cnt_r <= {STAT_W{1'b0}};
        end else begin
            beat_cnt_r  <= stats_nxt_s.beats;
            stall_cnt_r <= stats_nxt_s.stalls;
        end
    end

    assign stat_beats  = beat_cnt_r;
    assign stat_stalls = stall_cnt_r;
    assign stat_starve = m_ready && !m_valid && fifo_empty;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Randomized self-checking bench: both read latencies against a FIFO model
// and an in-order scoreboard of every word written into the FIFO.
module tb_fifo_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        fifo_clr = 1'b1;
    logic        push_req = 1'b0;
    logic [63:0] push_val = 64'd0;
    logic        rdy = 1'b0;
    int          sel = 0;

    // FIFO model shared by whichever adapter instance is active
    logic [63:0] mem [256];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    logic [63:0] rdata_q = 64'd0;
    logic [63:0] exp_q [$];

    logic        empty0, empty1, ren0, ren1, mv0, mv1, mr0, mr1;
    logic [63:0] dout0, dout1, md0, md1;
    logic        ren_a, is_empty;

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] sb0, ss0, sb1, ss1;
    logic        st0, st1;
`endif

    assign is_empty = (wp == rp);
    assign empty0   = (sel == 0) ? is_empty : 1'b1;
    assign empty1   = (sel == 1) ? is_empty : 1'b1;
    assign dout0    = mem[rp];
    assign dout1    = rdata_q;
    assign mr0      = (sel == 0) ? rdy : 1'b0;
    assign mr1      = (sel == 1) ? rdy : 1'b0;
    assign ren_a    = (sel == 1) ? ren1 : ren0;

    fifo_stream_adapter #(.WIDTH(64), .READ_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(empty0), .fifo_dout(dout0),
        .fifo_ren(ren0), .m_valid(mv0), .m_data(md0), .m_ready(mr0)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        , .stat_beats(sb0), .stat_stalls(ss0), .stat_starve(st0)
`endif
    );

    fifo_stream_adapter #(.WIDTH(64), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(empty1), .fifo_dout(dout1),
        .fifo_ren(ren1), .m_valid(mv1), .m_data(md1), .m_ready(mr1)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        , .stat_beats(sb1), .stat_stalls(ss1), .stat_starve(st1)
`endif
    );

    // FIFO behaviour: FWFT head on dout0, registered read data on dout1
    always @(posedge clk) begin
        if (fifo_clr) begin
            wp <= 8'd0;
            rp <= 8'd0;
            exp_q.delete();
        end else begin
            if (push_req) begin
                mem[wp] <= push_val;
                wp <= wp + 8'd1;
                exp_q.push_back(push_val);
            end
            if (ren_a) begin
                rdata_q <= mem[rp];
                rp <= rp + 8'd1;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (latency %0d)", tag, obs, exp, sel);
        end
    endtask

    int          cyc, ren_cnt, beats, first_ren, first_valid, last_beat, stalls;
    logic        prev_hold;
    logic [63:0] prev_data, first_beat;

    task automatic clear_stats();
        cyc = 0; ren_cnt = 0; beats = 0; stalls = 0;
        first_ren = -1; first_valid = -1; last_beat = -1;
        prev_hold = 1'b0; first_beat = 64'd0;
    endtask

    function automatic logic act_valid();
        return (sel == 1) ? mv1 : mv0;
    endfunction

    function automatic logic [63:0] act_data();
        return (sel == 1) ? md1 : md0;
    endfunction

    function automatic logic act_ren();
        return (sel == 1) ? ren1 : ren0;
    endfunction

    // Sample the active instance for the coming edge, score it, advance one cycle
    task automatic step();
        logic        v, rn;
        logic [63:0] d, e;
        #1;
        v  = act_valid();
        d  = act_data();
        rn = act_ren();
        if (reset) begin
            check_val("ren_in_reset", {63'd0, rn}, 64'd0);
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_val("hold_valid", {63'd0, v}, 64'd1);
                check_val("hold_data", d, prev_data);
            end
            if (rn) begin
                if (first_ren < 0) first_ren = cyc;
                ren_cnt++;
            end
            if (v && first_valid < 0) first_valid = cyc;
            if (v && !rdy) stalls++;
            if (v && rdy) begin
                check_val("beat_avail", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("beat_data", d, e);
                end
                beats++;
                last_beat = cyc;
                if (beats == 1) first_beat = d;
            end
            prev_hold = v && !rdy;
            prev_data = d;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int nwords, input logic [63:0] base);
        reset = 1'b1;
        fifo_clr = 1'b1;
        push_req = 1'b0;
        step();
        fifo_clr = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            push_req = 1'b1;
            push_val = base + 64'(i);
            step();
        end
        push_req = 1'b0;
        step();
        check_val("rst_valid", {63'd0, act_valid()}, 64'd0);
        reset = 1'b0;
        clear_stats();
    endtask

    initial begin
        @(negedge clk);
        for (int rl = 0; rl < 2; rl++) begin
            sel = rl;

            // fill and drain at full rate
            rdy = 1'b1;
            do_reset(8, 64'd1);
            for (int i = 0; i < 30; i++) step();
            check_val("fill_latency", 64'(first_valid - first_ren), 64'(1 + rl));
            check_val("fill_beats", 64'(beats), 64'd8);
            check_val("fill_no_gap", 64'(last_beat - first_valid), 64'd7);
            check_val("fill_first", first_beat, 64'd1);
            check_val("fill_sb_empty", 64'(exp_q.size()), 64'd0);

            // backpressure: issue stops at the buffer depth
            rdy = 1'b0;
            do_reset(8, 64'd1);
            for (int i = 0; i < 10; i++) step();
            check_val("bp_ren_cnt", 64'(ren_cnt), 64'(2 + rl));
            check_val("bp_valid", {63'd0, act_valid()}, 64'd1);
            check_val("bp_data", act_data(), 64'd1);
            rdy = 1'b1;
            for (int i = 0; i < 20; i++) step();
            check_val("bp_beats", 64'(beats), 64'd8);
            check_val("bp_sb_empty", 64'(exp_q.size()), 64'd0);

            // alternating ready against a writer on every other cycle
            rdy = 1'b0;
            do_reset(0, 64'd0);
            for (int i = 0; i < 60; i++) begin
                rdy = i[0];
                push_req = !i[0];
                push_val = {$urandom, $urandom};
                step();
            end
            push_req = 1'b0;
            rdy = 1'b1;
            for (int i = 0; i < 10; i++) step();
            check_val("alt_beats", 64'(beats), 64'd30);
            check_val("alt_sb_empty", 64'(exp_q.size()), 64'd0);

            // reset while the buffer holds data and a read is in flight
            rdy = 1'b0;
            do_reset(8, 64'd1);
            for (int i = 0; i < 10 && ren_cnt < 2 + rl; i++) step();
            check_val("mid_ren_cnt", 64'(ren_cnt), 64'(2 + rl));
            check_val("mid_valid_pre", {63'd0, act_valid()}, 64'd1);
            reset = 1'b1;
            fifo_clr = 1'b1;
            step();
            reset = 1'b0;
            fifo_clr = 1'b0;
            #1;
            check_val("mid_valid_post", {63'd0, act_valid()}, 64'd0);
            check_val("mid_ren_post", {63'd0, act_ren()}, 64'd0);
            for (int i = 0; i < 3; i++) step();
            check_val("mid_no_stale", {63'd0, act_valid()}, 64'd0);
            clear_stats();
            push_req = 1'b1;
            push_val = 64'hA;
            step();
            push_val = 64'hB;
            step();
            push_req = 1'b0;
            rdy = 1'b1;
            for (int i = 0; i < 10; i++) step();
            check_val("mid_first_beat", first_beat, 64'hA);
            check_val("mid_beats", 64'(beats), 64'd2);
        end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        sel = 0;
        rdy = 1'b0;
        do_reset(5, 64'h10);
        for (int i = 0; i < 10 && stalls == 0; i++) step();
        step();
        step();
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_val("stat_model_stalls", 64'(stalls), 64'd3);
        check_val("stat_beats", {32'd0, sb0}, 64'd5);
        check_val("stat_stalls", {32'd0, ss0}, 64'd3);
        #1;
        check_val("stat_starve", {63'd0, st0}, 64'd1);
        rdy = 1'b0;
        push_req = 1'b1;
        push_val = 64'h77;
        step();
        push_req = 1'b0;
        for (int i = 0; i < 5 && !act_valid(); i++) step();
        force dut0.beat_cnt_r = 32'hFFFF_FFFF;
        step();
        release dut0.beat_cnt_r;
        rdy = 1'b1;
        step();
        step();
        check_val("stat_saturate", {32'd0, sb0}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Downstream stage of the synchronous FIFO.
- Drains the FIFO read port (ren/dout/empty) and presents the data as a valid/ready stream with full throughput.
- A small internal skid buffer absorbs FIFO read latency and consumer backpressure.
- m_ready has no combinational path to fifo_ren.

Parameters:
- WIDTH, 64, data width; must match the FIFO WIDTH.
- READ_LATENCY, 0, FIFO read latency. 0 = dout shows head while ren is high (first-word-fall-through). 1 = dout valid the cycle after ren. Other values are illegal (elaboration $error).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  WIDTH  FIFO read data.
- fifo_ren  output  1  FIFO read enable.
- m_valid  output  1  stream data valid.
- m_data  output  WIDTH  stream data.
- m_ready  input  1  consumer ready.

Behaviour:
- Constants:
  - BUF_DEPTH = READ_LATENCY + 2 (2 or 3 entries).
  - Circular buffer with rd_ptr, wr_ptr and occ (0..BUF_DEPTH).
  - inflight: count of issued reads whose data has not yet landed (0 or 1; always 0 when READ_LATENCY=0).
- Issue:
  - fifo_ren = !reset && !fifo_empty && (occ + inflight) < BUF_DEPTH.
  - fifo_ren is combinational from registers and fifo_empty only.
- Capture, READ_LATENCY=0: when fifo_ren=1, fifo_dout is written at buffer[wr_ptr] on the same edge.
- Capture, READ_LATENCY=1:
  - inflight <= fifo_ren.
  - When inflight=1, fifo_dout is written at buffer[wr_ptr].
- Output:
  - m_valid = (occ != 0).
  - m_data = buffer[rd_ptr], driven straight from the registered buffer.
  - Pop when m_valid && m_ready.
- Simultaneous push and pop: occ is unchanged and both pointers advance. Pointers wrap from BUF_DEPTH-1 to 0.
- Stream rule: once m_valid=1, m_valid and m_data stay stable until the transfer. Order is strictly FIFO.
- Latency from first word, FIFO non-empty and buffer empty:
  - READ_LATENCY=0: m_valid rises 1 cycle after fifo_ren.
  - READ_LATENCY=1: m_valid rises 2 cycles after fifo_ren.
- Throughput: 1 beat/cycle sustained while fifo_empty=0 and m_ready=1.
- Backpressure: with m_ready=0, the buffer fills to BUF_DEPTH and fifo_ren drops. No data is lost or duplicated.
- fifo_empty asserted: no issue. An in-flight read still lands.
- Reset (any time, including mid-transfer), takes effect on the clock edge:
  - occ, inflight, rd_ptr, wr_ptr and the stats counters go to 0.
  - m_valid=0.
  - fifo_ren=0 while reset is high.
  - Buffered and in-flight data are discarded; the FIFO shares this reset.
  - m_data is don't-care while m_valid=0. The buffer RAM is not reset.
- No illegal states: occ never exceeds BUF_DEPTH by construction. A SVA assertion checks occ + inflight <= BUF_DEPTH.

Optional Feature:
- FIFO_STREAM_ADAPTER_STATS_EN defined adds three outputs and two counters:
  - stat_beats [31:0]: increments on each m_valid && m_ready.
  - stat_stalls [31:0]: increments on each m_valid && !m_ready.
  - stat_starve: 1-cycle pulse when m_ready && !m_valid && fifo_empty.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Macro undefined: these ports and counters do not exist. Datapath behaviour is identical either way.

Decomposition:
- Package fifo_stream_pkg:
  - function buf_depth(read_latency).
  - localparam STAT_W = 32.
  - typedef stream_stats_t (beats, stalls).
- One sub-module, stream_skid_buf: parameterised WIDTH/DEPTH circular buffer with push/pop/occ. The top holds issue/inflight control.

Test Plan:
- Fill and drain: READ_LATENCY=0, FIFO preloaded with 8 words 64'h1..64'h8, m_ready=1 -> m_data 1..8 on 8 consecutive m_valid cycles, first m_valid 1 cycle after first fifo_ren.
- Registered read: READ_LATENCY=1, same 8 words, m_ready=1 -> first m_valid 2 cycles after first fifo_ren, then 8 back-to-back beats, no gaps.
- Backpressure: m_ready=0 with 8 words queued -> fifo_ren count stops at BUF_DEPTH (2 for latency 0, 3 for latency 1), m_data holds 64'h1. Releasing m_ready delivers 1..8 in order.
- Alternating: m_ready toggles every cycle and the writer feeds every other cycle with $urandom data -> scoreboard matches every beat, no loss or duplicate.
- Mid-transfer reset: reset=1 for 1 cycle with occ=2 and inflight=1 -> next cycle m_valid=0 and fifo_ren=0. After the FIFO refills with 64'hA, the first beat is 64'hA.
- Stats (macro defined): 5 transfers and 3 stall cycles -> stat_beats=5, stat_stalls=3. Preloading a counter to 32'hFFFF_FFFF via force and adding one more beat -> counter stays saturated.
